// File: rtl/ps2_scan_sequencer_pkg.sv
// ps2_scan_sequencer_pkg
// Shared PS/2 keyboard definitions: the prefix bytes (0xE0 extended,
// 0xF0 break), the keyboard control/response bytes that never carry a
// scan code, and the state encoding of the scan-code sequencer FSM.
package ps2_scan_sequencer_pkg;

  // Prefix bytes
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Control / response bytes sent by the keyboard
  localparam logic [7:0] PS2_CTRL_ERR0  = 8'h00;  // key detection error
  localparam logic [7:0] PS2_CTRL_BAT   = 8'hAA;  // self-test passed
  localparam logic [7:0] PS2_CTRL_ECHO  = 8'hEE;  // echo response
  localparam logic [7:0] PS2_CTRL_ACK   = 8'hFA;  // command acknowledge
  localparam logic [7:0] PS2_CTRL_BATF  = 8'hFC;  // self-test failed
  localparam logic [7:0] PS2_CTRL_RSND  = 8'hFE;  // resend request
  localparam logic [7:0] PS2_CTRL_ERR1  = 8'hFF;  // key detection error

  // Sequencer FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    logic r;
    r = 1'b0;
    case (b)
      PS2_CTRL_ERR0, PS2_CTRL_BAT, PS2_CTRL_ECHO, PS2_CTRL_ACK,
      PS2_CTRL_BATF, PS2_CTRL_RSND, PS2_CTRL_ERR1: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_scan_sequencer_prefix_timer.sv
// ps2_prefix_timer
// Saturating timeout counter for partially received prefix sequences.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   clr         - synchronous clear (has priority over counting)
//   en          - count enable
//   expire      - high while enabled and the count sits at TIMEOUT_CYC-1
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      // Stops at CNT_MAX so a long idle gap can never wrap back to zero.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
// Assembles PS/2 set-2 byte streams (optional 0xE0 / 0xF0 prefixes
// followed by a scan code) into single key events held in an output
// register until acknowledged.
// Ports:
//   clk, reset    - clock, asynchronous active-low reset
//   rx_done_tick  - strobe: din carries a new received byte
//   din[7:0]      - received byte
//   key_ack       - consumer has taken the presented event
//   key_valid     - event register holds an unconsumed event
//   key_code[7:0] - scan code with prefixes stripped
//   key_ext       - event had an 0xE0 prefix
//   key_break     - event is a key release (0xF0 prefix)
//   ovf           - sticky: an event was dropped since the last ack
//   err           - one-cycle pulse on prefix timeout or protocol error
module ps2_scan_sequencer
  import ps2_scan_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  input  logic       key_ack,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       ovf,
  output logic       err
);

  logic [1:0] state_q, state_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_break_q, key_break_d;
  logic       ovf_q, ovf_d;
  logic       err_q, err_d;

  logic tmo_expire;
  logic tmo_fire;
  logic evt;
  logic evt_ext;
  logic evt_brk;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_fire = tmo_expire && !rx_done_tick;

  ps2_prefix_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (rx_done_tick || tmo_fire),
    .en    (state_q != ST_IDLE),
    .expire(tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    ovf_d       = ovf_q;
    err_d       = 1'b0;
    evt         = 1'b0;
    evt_ext     = 1'b0;
    evt_brk     = 1'b0;

    if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end

    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (din == PS2_PREFIX_EXT) begin
            state_d = ST_EXT;
          end else if (din == PS2_PREFIX_BRK) begin
            state_d = ST_BRK;
          end else if (!is_ctrl_byte(din)) begin
            evt = 1'b1;
          end
        end
        ST_EXT: begin
          if (din == PS2_PREFIX_BRK) begin
            state_d = ST_EXT_BRK;
          end else if ((din == PS2_PREFIX_EXT) || is_ctrl_byte(din)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            evt     = 1'b1;
            evt_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin  // ST_BRK, ST_EXT_BRK
          if ((din == PS2_PREFIX_EXT) || (din == PS2_PREFIX_BRK) ||
              is_ctrl_byte(din)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            evt     = 1'b1;
            evt_ext = (state_q == ST_EXT_BRK);
            evt_brk = 1'b1;
            state_d = ST_IDLE;
          end
        end
      endcase
    end else if (tmo_fire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    // An event may load only into an empty register or one being acked
    // this very cycle; otherwise it is dropped and flagged.
    if (evt) begin
      if (!key_valid_q || key_ack) begin
        key_valid_d = 1'b1;
        key_code_d  = din;
        key_ext_d   = evt_ext;
        key_break_d = evt_brk;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb_ps2_scan_sequencer
// Directed bench for ps2_scan_sequencer with a short prefix timeout.
module tb_ps2_scan_sequencer;

  localparam int TMO = 16;

  logic       clk;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] din;
  logic       key_ack;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       ovf;
  logic       err;

  int total = 0;
  int bad   = 0;

  ps2_scan_sequencer #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .din         (din),
    .key_ack     (key_ack),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .ovf         (ovf),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one byte for one cycle; returns on the negedge after the
  // sampling edge, when the registered result is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    din          = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
    din          = 8'h00;
  endtask

  task automatic do_ack();
    @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  // Compare the full event register against expected values.
  task automatic check_evt(input string nm, input logic v, input logic [7:0] c,
                           input logic e, input logic b, input logic o,
                           input logic er);
    total++;
    if ({key_valid, key_code, key_ext, key_break, ovf, err} !== {v, c, e, b, o, er}) begin
      bad++;
      $display("FAIL %s: got valid=%b code=%h ext=%b brk=%b ovf=%b err=%b, want valid=%b code=%h ext=%b brk=%b ovf=%b err=%b",
               nm, key_valid, key_code, key_ext, key_break, ovf, err, v, c, e, b, o, er);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_done_tick = 1'b0;
    din = 8'h00;
    key_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_evt("reset_state", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_evt("after_release", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_make();
    send_byte(8'h1C);
    check_evt("make_1c", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack();
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL make_ack: key_valid=%b want 0", key_valid);
    end
    // ack with nothing pending must not disturb anything
    do_ack();
    check_evt("idle_ack", 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ext_break();
    send_byte(8'hE0);
    check_evt("ext_prefix", 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hF0);
    check_evt("ext_brk_prefix", 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h75);
    check_evt("ext_brk_75", 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
    do_ack();
    check_evt("ext_brk_ack", 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
    // plain break
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_evt("brk_1c", 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    do_ack();
  endtask

  task automatic test_overflow();
    send_byte(8'h1C);
    check_evt("ovf_first", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h32);
    check_evt("ovf_dropped", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_evt("ovf_sticky", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    do_ack();
    check_evt("ovf_ack", 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    send_byte(8'hF0);
    for (int i = 0; i < 2 * TMO; i++) begin
      @(negedge clk);
      if (err === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL timeout_pulses: got %0d err pulses want 1", pulses);
    end
    send_byte(8'h1C);
    check_evt("timeout_then_1c", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack();
  endtask

  task automatic test_timeout_race();
    int pulses;
    pulses = 0;
    send_byte(8'hF0);
    // wait until the cycle in which the counter sits at TMO-1
    for (int i = 0; i < TMO - 2; i++) begin
      @(negedge clk);
      if (err === 1'b1) pulses++;
    end
    send_byte(8'h1C);
    if (err === 1'b1) pulses++;
    check_evt("race_event", 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TMO + 4; i++) begin
      @(negedge clk);
      if (err === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL race_no_err: got %0d err pulses want 0", pulses);
    end
    do_ack();
  endtask

  task automatic test_protocol_err();
    send_byte(8'hE0);
    send_byte(8'hFA);
    check_evt("proto_err", 1'b0, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_evt("proto_err_1cyc", 1'b0, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hAA);
    check_evt("ctrl_idle", 1'b0, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hF0);
    send_byte(8'hF0);
    check_evt("brk_brk_err", 1'b0, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
    // FSM back in IDLE: next byte decodes plain
    send_byte(8'h2B);
    check_evt("after_err_2b", 1'b1, 8'h2B, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack();
  endtask

  task automatic test_reset_mid();
    send_byte(8'hE0);
    #2 reset = 1'b0;
    #1;
    check_evt("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'h29);
    check_evt("post_reset_29", 1'b1, 8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // key_valid=1 from previous test; ack and new event in one cycle
    @(negedge clk);
    key_ack      = 1'b1;
    rx_done_tick = 1'b1;
    din          = 8'h4B;
    @(negedge clk);
    key_ack      = 1'b0;
    rx_done_tick = 1'b0;
    din          = 8'h00;
    check_evt("b2b_load", 1'b1, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b0);
    // drop one, then ack + new event together: ovf clears, new code shown
    send_byte(8'h33);
    check_evt("b2b_drop", 1'b1, 8'h4B, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    key_ack      = 1'b1;
    rx_done_tick = 1'b1;
    din          = 8'h5A;
    @(negedge clk);
    key_ack      = 1'b0;
    rx_done_tick = 1'b0;
    din          = 8'h00;
    check_evt("b2b_ovf_clear", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack();
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_overflow();
    test_timeout();
    test_timeout_race();
    test_protocol_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scan_sequencer.md
PS2_SCAN_SEQUENCER -- requirements
Module: ps2_scan_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 200000, is the prefix timeout in clk cycles (4 ms at 50 MHz).
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-004 rx_done_tick  in  1  one-cycle strobe: din holds a new received keyboard byte.
REQ-005 din  in  8  received byte, valid only while rx_done_tick=1.
REQ-006 key_ack  in  1  consumer has taken the current event.
REQ-007 key_valid  out  1  event register holds an unconsumed event.
REQ-008 key_code  out  8  scan code of the event (prefix bytes stripped).
REQ-009 key_ext  out  1  event was preceded by 0xE0.
REQ-010 key_break  out  1  event is a release (0xF0 seen), 0 = press.
REQ-011 ovf  out  1  sticky: at least one event was dropped since the last key_ack.
REQ-012 err  out  1  one-cycle pulse on a prefix timeout or a protocol error.

Function
REQ-013 FSM states: IDLE, EXT (0xE0 seen), BRK (0xF0 seen), EXT_BRK (0xE0 then 0xF0 seen).
REQ-014 Bytes are consumed only in cycles with rx_done_tick=1; din is ignored otherwise.
REQ-015 IDLE: 0xE0 -> EXT; 0xF0 -> BRK.
REQ-016 EXT: 0xF0 -> EXT_BRK.
REQ-017 Control bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF received in IDLE are discarded: no event, no err.
REQ-018 The same control bytes, 0xE0 received in EXT/BRK/EXT_BRK, or 0xF0 received in BRK/EXT_BRK are protocol errors: err pulses and the FSM goes to IDLE.
REQ-019 Any other byte completes an event: code=din; ext=1 if the state is EXT or EXT_BRK; break=1 if the state is BRK or EXT_BRK; the FSM goes to IDLE.
REQ-020 A completed event appears on key_* with key_valid=1 in the cycle after the rx_done_tick edge (latency 1).
REQ-021 key_code, key_ext and key_break are stable while key_valid=1 and no new event is loaded.
REQ-022 key_ack while key_valid=1 clears key_valid and ovf on the next edge; key_ack while key_valid=0 has no effect.
REQ-023 If an event completes while key_valid=1 and key_ack=0, the event is dropped, the outputs are unchanged, and ovf is set.
REQ-024 If an event completes in the same cycle as key_ack=1, the new event is loaded, key_valid stays 1, and ovf is cleared, not set.
REQ-025 The timeout counter clears on every consumed byte and counts while the FSM is in EXT, BRK or EXT_BRK.
REQ-026 When the count reaches TIMEOUT_CYC-1 with no byte, err pulses and the FSM goes to IDLE.
REQ-027 If rx_done_tick arrives in the timeout cycle, the byte is processed normally and the timeout is suppressed.
REQ-028 The counter width is ceil(log2(TIMEOUT_CYC)) bits; the counter saturates and never wraps.

Reset
REQ-029 reset=0 asynchronously forces: FSM=IDLE, counter=0, key_valid=0, key_code=0x00, key_ext=0, key_break=0, ovf=0, err=0.
REQ-030 Reset asserted mid-sequence (for example after 0xE0) discards the partial sequence; the first byte after release is decoded from IDLE.
REQ-031 Reset release is synchronised by the system reset tree; the block adds no synchroniser.

Structure
REQ-032 The shared PS/2 package holds: prefix constants 0xE0 and 0xF0, the control-byte constants, and the FSM state encoding.
REQ-033 A single sub-module, ps2_prefix_timer, implements the parameterised saturating timeout counter with clear and enable inputs and a one-cycle expire output.
REQ-034 All outputs are registered; there are no combinational paths from inputs to outputs.

Verification
REQ-035 Bytes 0x1C -> one event {code 0x1C, ext 0, break 0}; key_ack -> key_valid=0.
REQ-036 Bytes 0xE0, 0xF0, 0x75 with key_ack after each event -> one event {0x75, ext 1, break 1}; err never pulses.
REQ-037 Event 0x1C held without ack, then 0x32 arrives -> outputs keep 0x1C and ovf=1; key_ack -> ovf=0 and key_valid=0.
REQ-038 0xF0 followed by TIMEOUT_CYC idle cycles (run with TIMEOUT_CYC=16) -> err pulses once; a following 0x1C yields {0x1C, break 0}.
REQ-039 0xE0, then 0xFA -> err pulses and no event; 0xAA in IDLE -> no event and no err.
REQ-040 Reset asserted after 0xE0 -> all outputs are zero; after release, 0x29 yields {0x29, ext 0}; ack and new event in the same cycle -> key_valid stays 1 and the new code is presented.
